tt_ovi_issue: RTL and testbench

TT_OVI_ISSUE -- requirements
Module: tt_ovi_issue

---
 rtl/tt_ovi_issue_if.sv | 66 ++++++
 rtl/tt_ovi_issue.sv | 137 +++++++++++++
 tb/tb_tt_ovi_issue.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tt_ovi_issue_if.sv
// OVI issue-unit bus: core request/commit, VPU issue/dispatch/completion, completion to core.
// The slave modport is the issue unit; the master modport is the core/VPU side.
interface tt_ovi_issue_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_inst;
   logic [63:0] req_scalar_opnd;
   logic [39:0] req_vcsr;
   logic        req_vcsr_lmulb2;
   logic [4:0]  req_sb_id;

   logic        sen_valid;
   logic        sen_kill;

   logic        issue_valid;
   logic [31:0] issue_inst;
   logic [4:0]  issue_sb_id;
   logic [63:0] issue_scalar_opnd;
   logic [39:0] issue_vcsr;
   logic        issue_vcsr_lmulb2;
   logic        issue_credit;

   logic [4:0]  dispatch_sb_id;
   logic        dispatch_next_senior;
   logic        dispatch_kill;

   logic        completed_valid;
   logic [4:0]  completed_sb_id;
   logic [4:0]  completed_fflags;
   logic [63:0] completed_dest_reg;
   logic        completed_vxsat;
   logic [13:0] completed_vstart;
   logic        completed_illegal;

   logic        cpl_valid;
   logic [4:0]  cpl_sb_id;
   logic [4:0]  cpl_fflags;
   logic [63:0] cpl_dest_reg;
   logic        cpl_vxsat;
   logic [13:0] cpl_vstart;
   logic        cpl_illegal;

   modport slave (
      input  req_valid, req_inst, req_scalar_opnd, req_vcsr, req_vcsr_lmulb2,
      output req_ready, req_sb_id,
      input  sen_valid, sen_kill,
      output issue_valid, issue_inst, issue_sb_id, issue_scalar_opnd, issue_vcsr, issue_vcsr_lmulb2,
      input  issue_credit,
      output dispatch_sb_id, dispatch_next_senior, dispatch_kill,
      input  completed_valid, completed_sb_id, completed_fflags, completed_dest_reg,
             completed_vxsat, completed_vstart, completed_illegal,
      output cpl_valid, cpl_sb_id, cpl_fflags, cpl_dest_reg, cpl_vxsat, cpl_vstart, cpl_illegal
   );

   modport master (
      output req_valid, req_inst, req_scalar_opnd, req_vcsr, req_vcsr_lmulb2,
      input  req_ready, req_sb_id,
      output sen_valid, sen_kill,
      input  issue_valid, issue_inst, issue_sb_id, issue_scalar_opnd, issue_vcsr, issue_vcsr_lmulb2,
      output issue_credit,
      input  dispatch_sb_id, dispatch_next_senior, dispatch_kill,
      output completed_valid, completed_sb_id, completed_fflags, completed_dest_reg,
             completed_vxsat, completed_vstart, completed_illegal,
      input  cpl_valid, cpl_sb_id, cpl_fflags, cpl_dest_reg, cpl_vxsat, cpl_vstart, cpl_illegal
   );
endinterface

// File: rtl/tt_ovi_issue.sv
// OVI issue unit: credit-gated issue, scoreboard-ID allocation, in-order dispatch, completion relay.
// Define TT_OVI_ISSUE_CHECK_EN to build the sticky protocol checker driving proto_err.
module tt_ovi_issue #(
   parameter int INIT_CREDITS = 4,
   parameter int SB_DEPTH     = 32
) (
   input  logic           clk,
   input  logic           reset_n,
   tt_ovi_issue_if.slave  ovi,
   output logic           proto_err
);
   localparam int CRED_W = $clog2(INIT_CREDITS + 1);
   localparam int PEND_W = $clog2(SB_DEPTH + 1) + 1;
   localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(INIT_CREDITS);
   localparam logic [4:0]        SB_LAST  = 5'(SB_DEPTH - 1);

   logic [CRED_W-1:0]   credits;
   logic [4:0]          alloc_ptr;
   logic [4:0]          disp_ptr;
   logic [PEND_W-1:0]   pending;
   logic [SB_DEPTH-1:0] busy;
   logic [SB_DEPTH-1:0] busy_nxt;

   logic accept;
   logic sen_any;
   logic do_disp;
   logic do_kill;

   assign ovi.req_ready = (credits != '0) && !busy[alloc_ptr];
   assign ovi.req_sb_id = alloc_ptr;
   assign accept        = ovi.req_valid && ovi.req_ready;
   assign sen_any       = ovi.sen_valid || ovi.sen_kill;
   assign do_disp       = sen_any && (pending != '0);
   assign do_kill       = ovi.sen_kill && (pending != '0);

   // Accept is applied last so it wins over a same-cycle clear of the same ID.
   always_comb begin
      busy_nxt = busy;
      if (ovi.completed_valid) busy_nxt[ovi.completed_sb_id] = 1'b0;
      if (do_kill)             busy_nxt[disp_ptr]            = 1'b0;
      if (accept)              busy_nxt[alloc_ptr]           = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         credits   <= CRED_MAX;
         alloc_ptr <= '0;
         disp_ptr  <= '0;
         pending   <= '0;
         busy      <= '0;
      end else begin
         busy <= busy_nxt;
         if (accept && !ovi.issue_credit)
            credits <= credits - CRED_W'(1);
         else if (!accept && ovi.issue_credit && (credits != CRED_MAX))
            credits <= credits + CRED_W'(1);
         if (accept)
            alloc_ptr <= (alloc_ptr == SB_LAST) ? 5'd0 : alloc_ptr + 5'd1;
         if (do_disp)
            disp_ptr <= (disp_ptr == SB_LAST) ? 5'd0 : disp_ptr + 5'd1;
         if (accept && !do_disp)
            pending <= pending + PEND_W'(1);
         else if (!accept && do_disp)
            pending <= pending - PEND_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ovi.issue_valid       <= 1'b0;
         ovi.issue_inst        <= '0;
         ovi.issue_sb_id       <= '0;
         ovi.issue_scalar_opnd <= '0;
         ovi.issue_vcsr        <= '0;
         ovi.issue_vcsr_lmulb2 <= 1'b0;
      end else begin
         ovi.issue_valid <= accept;
         if (accept) begin
            ovi.issue_inst        <= ovi.req_inst;
            ovi.issue_sb_id       <= alloc_ptr;
            ovi.issue_scalar_opnd <= ovi.req_scalar_opnd;
            ovi.issue_vcsr        <= ovi.req_vcsr;
            ovi.issue_vcsr_lmulb2 <= ovi.req_vcsr_lmulb2;
         end
      end
   end

   // Dispatch fields return to zero between pulses; a kill overrides a simultaneous commit.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ovi.dispatch_sb_id       <= '0;
         ovi.dispatch_next_senior <= 1'b0;
         ovi.dispatch_kill        <= 1'b0;
      end else begin
         ovi.dispatch_sb_id       <= do_disp ? disp_ptr : 5'd0;
         ovi.dispatch_next_senior <= do_disp && !ovi.sen_kill;
         ovi.dispatch_kill        <= do_kill;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ovi.cpl_valid    <= 1'b0;
         ovi.cpl_sb_id    <= '0;
         ovi.cpl_fflags   <= '0;
         ovi.cpl_dest_reg <= '0;
         ovi.cpl_vxsat    <= 1'b0;
         ovi.cpl_vstart   <= '0;
         ovi.cpl_illegal  <= 1'b0;
      end else begin
         ovi.cpl_valid <= ovi.completed_valid;
         if (ovi.completed_valid) begin
            ovi.cpl_sb_id    <= ovi.completed_sb_id;
            ovi.cpl_fflags   <= ovi.completed_fflags;
            ovi.cpl_dest_reg <= ovi.completed_dest_reg;
            ovi.cpl_vxsat    <= ovi.completed_vxsat;
            ovi.cpl_vstart   <= ovi.completed_vstart;
            ovi.cpl_illegal  <= ovi.completed_illegal;
         end
      end
   end

`ifdef TT_OVI_ISSUE_CHECK_EN
   logic err_now;
   assign err_now = (ovi.completed_valid && !busy[ovi.completed_sb_id])
                 || (ovi.issue_credit && (credits == CRED_MAX))
                 || (sen_any && (pending == '0));

   always_ff @(posedge clk) begin
      if (!reset_n)     proto_err <= 1'b0;
      else if (err_now) proto_err <= 1'b1;
   end
`else
   assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_tt_ovi_issue.sv
// Directed bench for tt_ovi_issue: credits, dispatch/commit, kill, ID wrap, mid-run reset, checker.
module tb_tt_ovi_issue;
   logic clk = 1'b0;
   logic reset_n;
   logic proto_err;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   tt_ovi_issue_if bus ();

   tt_ovi_issue dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .ovi       (bus.slave),
      .proto_err (proto_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.req_valid          = 1'b0;
      bus.req_inst           = '0;
      bus.req_scalar_opnd    = '0;
      bus.req_vcsr           = '0;
      bus.req_vcsr_lmulb2    = 1'b0;
      bus.sen_valid          = 1'b0;
      bus.sen_kill           = 1'b0;
      bus.issue_credit       = 1'b0;
      bus.completed_valid    = 1'b0;
      bus.completed_sb_id    = '0;
      bus.completed_fflags   = '0;
      bus.completed_dest_reg = '0;
      bus.completed_vxsat    = 1'b0;
      bus.completed_vstart   = '0;
      bus.completed_illegal  = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++;
      if ({bus.req_ready, bus.req_sb_id} !== {1'b1, 5'd0}) begin
         n_err++; $display("FAIL reset_req: ready/sb_id got %b/%0d want 1/0", bus.req_ready, bus.req_sb_id);
      end
      n_vec++;
      if ({bus.issue_valid, bus.dispatch_next_senior, bus.dispatch_kill, bus.dispatch_sb_id, bus.cpl_valid} !== 9'd0) begin
         n_err++; $display("FAIL reset_pulses: iv/ns/kill/dsb/cv got %b%b%b %0d %b want all 0",
            bus.issue_valid, bus.dispatch_next_senior, bus.dispatch_kill, bus.dispatch_sb_id, bus.cpl_valid);
      end
      n_vec++;
      if ({bus.cpl_sb_id, bus.cpl_fflags, bus.cpl_dest_reg, bus.cpl_vxsat, bus.cpl_vstart, bus.cpl_illegal, proto_err} !== '0) begin
         n_err++; $display("FAIL reset_cpl_payload: got dest %h sb %0d perr %b want 0", bus.cpl_dest_reg, bus.cpl_sb_id, proto_err);
      end
   endtask

   task automatic test_credits();
      do_reset();
      bus.issue_credit = 1'b1;   // at full credits: must saturate, not grow to 5
      step();
      bus.issue_credit = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.req_valid       = 1'b1;
         bus.req_inst        = 32'h1000_0000 + 32'(i);
         bus.req_scalar_opnd = 64'hA000 + 64'(i);
         bus.req_vcsr        = 40'h55_0000_0000 | 40'(i);
         bus.req_vcsr_lmulb2 = i[0];
         n_vec++;
         if ({bus.req_ready, bus.req_sb_id} !== {1'b1, 5'(i)}) begin
            n_err++; $display("FAIL credit_ready[%0d]: ready/sb got %b/%0d want 1/%0d", i, bus.req_ready, bus.req_sb_id, i);
         end
         step();
         n_vec++;
         if ({bus.issue_valid, bus.issue_sb_id, bus.issue_inst} !== {1'b1, 5'(i), 32'h1000_0000 + 32'(i)}) begin
            n_err++; $display("FAIL credit_issue[%0d]: v/sb/inst got %b/%0d/%h want 1/%0d/%h",
               i, bus.issue_valid, bus.issue_sb_id, bus.issue_inst, i, 32'h1000_0000 + 32'(i));
         end
         n_vec++;
         if ({bus.issue_scalar_opnd, bus.issue_vcsr, bus.issue_vcsr_lmulb2} !==
             {64'hA000 + 64'(i), 40'h55_0000_0000 | 40'(i), i[0]}) begin
            n_err++; $display("FAIL credit_payload[%0d]: opnd/vcsr/lmulb2 got %h/%h/%b", i,
               bus.issue_scalar_opnd, bus.issue_vcsr, bus.issue_vcsr_lmulb2);
         end
      end
      n_vec++;
      if (bus.req_ready !== 1'b0) begin
         n_err++; $display("FAIL credit_fifth_ready: got %b want 0", bus.req_ready);
      end
      step();
      n_vec++;
      if (bus.issue_valid !== 1'b0) begin
         n_err++; $display("FAIL credit_no_fifth_issue: issue_valid got %b want 0", bus.issue_valid);
      end
      bus.req_valid    = 1'b0;
      bus.issue_credit = 1'b1;
      step();
      bus.issue_credit = 1'b0;
      n_vec++;
      if ({bus.req_ready, bus.req_sb_id} !== {1'b1, 5'd4}) begin
         n_err++; $display("FAIL credit_return: ready/sb got %b/%0d want 1/4", bus.req_ready, bus.req_sb_id);
      end
   endtask

   task automatic test_dispatch();
      do_reset();
      for (int i = 0; i < 6; i++) begin
         bus.req_valid    = 1'b1;
         bus.issue_credit = 1'b1;
         bus.req_inst     = 32'hC0DE_0000 + 32'(i);
         step();
      end
      bus.req_valid    = 1'b0;
      bus.issue_credit = 1'b0;
      n_vec++;
      if ({bus.issue_valid, bus.issue_sb_id, bus.issue_inst} !== {1'b1, 5'd5, 32'hC0DE_0005}) begin
         n_err++; $display("FAIL disp_issue5: v/sb/inst got %b/%0d/%h want 1/5/c0de0005",
            bus.issue_valid, bus.issue_sb_id, bus.issue_inst);
      end
      for (int i = 0; i < 6; i++) begin
         bus.sen_valid = 1'b1;
         step();
         n_vec++;
         if ({bus.dispatch_next_senior, bus.dispatch_kill, bus.dispatch_sb_id} !== {1'b1, 1'b0, 5'(i)}) begin
            n_err++; $display("FAIL disp_senior[%0d]: ns/kill/sb got %b/%b/%0d want 1/0/%0d",
               i, bus.dispatch_next_senior, bus.dispatch_kill, bus.dispatch_sb_id, i);
         end
      end
      bus.sen_valid = 1'b0;
      step();
      n_vec++;
      if ({bus.dispatch_next_senior, bus.dispatch_kill, bus.dispatch_sb_id} !== 7'd0) begin
         n_err++; $display("FAIL disp_one_cycle: ns/kill/sb got %b/%b/%0d want 0/0/0",
            bus.dispatch_next_senior, bus.dispatch_kill, bus.dispatch_sb_id);
      end
      bus.sen_valid = 1'b1;   // nothing pending: ignored
      step();
      bus.sen_valid = 1'b0;
      n_vec++;
      if ({bus.dispatch_next_senior, bus.dispatch_kill, bus.dispatch_sb_id} !== 7'd0) begin
         n_err++; $display("FAIL disp_empty_ignored: ns/kill/sb got %b/%b/%0d want 0/0/0",
            bus.dispatch_next_senior, bus.dispatch_kill, bus.dispatch_sb_id);
      end
      bus.completed_valid    = 1'b1;
      bus.completed_sb_id    = 5'd5;
      bus.completed_dest_reg = 64'hDEAD;
      bus.completed_fflags   = 5'h13;
      bus.completed_vxsat    = 1'b1;
      bus.completed_vstart   = 14'd7;
      bus.completed_illegal  = 1'b1;
      step();
      bus.completed_valid = 1'b0;
      n_vec++;
      if ({bus.cpl_valid, bus.cpl_sb_id, bus.cpl_dest_reg} !== {1'b1, 5'd5, 64'hDEAD}) begin
         n_err++; $display("FAIL cpl_main: v/sb/dest got %b/%0d/%h want 1/5/dead", bus.cpl_valid, bus.cpl_sb_id, bus.cpl_dest_reg);
      end
      n_vec++;
      if ({bus.cpl_fflags, bus.cpl_vxsat, bus.cpl_vstart, bus.cpl_illegal} !== {5'h13, 1'b1, 14'd7, 1'b1}) begin
         n_err++; $display("FAIL cpl_fields: ff/vxsat/vstart/ill got %h/%b/%0d/%b want 13/1/7/1",
            bus.cpl_fflags, bus.cpl_vxsat, bus.cpl_vstart, bus.cpl_illegal);
      end
      step();
      n_vec++;
      if (bus.cpl_valid !== 1'b0) begin
         n_err++; $display("FAIL cpl_one_cycle: cpl_valid got %b want 0", bus.cpl_valid);
      end
   endtask

   task automatic test_kill();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         bus.req_valid = 1'b1;
         step();
      end
      bus.req_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.sen_valid = 1'b1;
         step();
         n_vec++;
         if ({bus.dispatch_next_senior, bus.dispatch_kill, bus.dispatch_sb_id} !== {1'b1, 1'b0, 5'(i)}) begin
            n_err++; $display("FAIL kill_pre_senior[%0d]: ns/kill/sb got %b/%b/%0d want 1/0/%0d",
               i, bus.dispatch_next_senior, bus.dispatch_kill, bus.dispatch_sb_id, i);
         end
      end
      bus.sen_kill = 1'b1;
      step();
      bus.sen_valid = 1'b0;
      bus.sen_kill  = 1'b0;
      n_vec++;
      if ({bus.dispatch_next_senior, bus.dispatch_kill, bus.dispatch_sb_id} !== {1'b0, 1'b1, 5'd2}) begin
         n_err++; $display("FAIL kill_pulse: ns/kill/sb got %b/%b/%0d want 0/1/2",
            bus.dispatch_next_senior, bus.dispatch_kill, bus.dispatch_sb_id);
      end
      step();
      n_vec++;
      if ({bus.dispatch_next_senior, bus.dispatch_kill} !== 2'b00) begin
         n_err++; $display("FAIL kill_one_cycle: ns/kill got %b/%b want 0/0", bus.dispatch_next_senior, bus.dispatch_kill);
      end
      for (int i = 0; i < 2; i++) begin
         bus.completed_valid = 1'b1;
         bus.completed_sb_id = 5'(i);
         step();
      end
      bus.completed_valid = 1'b0;
      // Walk alloc_ptr 3..31,0,1 so it lands on the killed ID 2 without any completion for it.
      for (int k = 0; k < 31; k++) begin
         bus.req_valid    = 1'b1;
         bus.issue_credit = 1'b1;
         step();
      end
      n_vec++;
      if ({bus.issue_valid, bus.issue_sb_id} !== {1'b1, 5'd1}) begin
         n_err++; $display("FAIL kill_wrap_issue: v/sb got %b/%0d want 1/1", bus.issue_valid, bus.issue_sb_id);
      end
      n_vec++;
      if ({bus.req_ready, bus.req_sb_id} !== {1'b1, 5'd2}) begin
         n_err++; $display("FAIL kill_freed_id: ready/sb got %b/%0d want 1/2", bus.req_ready, bus.req_sb_id);
      end
      step();
      n_vec++;
      if ({bus.issue_sb_id, bus.req_ready, bus.req_sb_id} !== {5'd2, 1'b0, 5'd3}) begin
         n_err++; $display("FAIL kill_busy_block: isb/ready/sb got %0d/%b/%0d want 2/0/3",
            bus.issue_sb_id, bus.req_ready, bus.req_sb_id);
      end
      bus.req_valid    = 1'b0;
      bus.issue_credit = 1'b0;
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 32; i++) begin
         bus.req_valid       = 1'b1;
         bus.issue_credit    = 1'b1;
         bus.completed_valid = (i >= 2);
         bus.completed_sb_id = 5'(i - 1);
         step();
         n_vec++;
         if ({bus.issue_valid, bus.issue_sb_id} !== {1'b1, 5'(i)}) begin
            n_err++; $display("FAIL wrap_issue[%0d]: v/sb got %b/%0d want 1/%0d", i, bus.issue_valid, bus.issue_sb_id, i);
         end
      end
      bus.issue_credit    = 1'b0;
      bus.completed_valid = 1'b1;
      bus.completed_sb_id = 5'd31;
      n_vec++;
      if ({bus.req_ready, bus.req_sb_id} !== {1'b0, 5'd0}) begin
         n_err++; $display("FAIL wrap_ptr_block: ready/sb got %b/%0d want 0/0", bus.req_ready, bus.req_sb_id);
      end
      step();
      bus.completed_valid = 1'b0;
      step();
      n_vec++;
      if ({bus.req_ready, bus.issue_valid} !== 2'b00) begin
         n_err++; $display("FAIL wrap_hold: ready/issue_valid got %b/%b want 0/0", bus.req_ready, bus.issue_valid);
      end
      bus.completed_valid = 1'b1;
      bus.completed_sb_id = 5'd0;
      step();
      bus.completed_valid = 1'b0;
      n_vec++;
      if ({bus.req_ready, bus.req_sb_id, bus.issue_valid} !== {1'b1, 5'd0, 1'b0}) begin
         n_err++; $display("FAIL wrap_release: ready/sb/iv got %b/%0d/%b want 1/0/0", bus.req_ready, bus.req_sb_id, bus.issue_valid);
      end
      bus.issue_credit = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         n_vec++;
         if ({bus.issue_valid, bus.issue_sb_id} !== {1'b1, 5'(i)}) begin
            n_err++; $display("FAIL wrap_second_lap[%0d]: v/sb got %b/%0d want 1/%0d", i, bus.issue_valid, bus.issue_sb_id, i);
         end
      end
      bus.req_valid    = 1'b0;
      bus.issue_credit = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.req_valid = 1'b1;
      step();
      bus.sen_valid       = 1'b1;
      bus.completed_valid = 1'b1;
      bus.completed_sb_id = 5'd0;
      reset_n             = 1'b0;
      step();
      reset_n = 1'b1;
      idle_inputs();
      n_vec++;
      if ({bus.issue_valid, bus.dispatch_next_senior, bus.dispatch_kill, bus.cpl_valid} !== 4'd0) begin
         n_err++; $display("FAIL midreset_pulses: iv/ns/kill/cv got %b%b%b%b want 0000",
            bus.issue_valid, bus.dispatch_next_senior, bus.dispatch_kill, bus.cpl_valid);
      end
      n_vec++;
      if ({bus.req_ready, bus.req_sb_id} !== {1'b1, 5'd0}) begin
         n_err++; $display("FAIL midreset_alloc: ready/sb got %b/%0d want 1/0", bus.req_ready, bus.req_sb_id);
      end
      bus.sen_valid = 1'b1;
      step();
      bus.sen_valid = 1'b0;
      n_vec++;
      if (bus.dispatch_next_senior !== 1'b0) begin
         n_err++; $display("FAIL midreset_pending: next_senior got %b want 0", bus.dispatch_next_senior);
      end
   endtask

   task automatic test_proto();
      do_reset();
      bus.completed_valid = 1'b1;
      bus.completed_sb_id = 5'd9;
      step();
      bus.completed_valid = 1'b0;
`ifdef TT_OVI_ISSUE_CHECK_EN
      n_vec++;
      if (proto_err !== 1'b1) begin
         n_err++; $display("FAIL proto_set: got %b want 1", proto_err);
      end
      step();
      step();
      n_vec++;
      if (proto_err !== 1'b1) begin
         n_err++; $display("FAIL proto_sticky: got %b want 1", proto_err);
      end
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      n_vec++;
      if ({proto_err, bus.req_ready} !== 2'b01) begin
         n_err++; $display("FAIL proto_clear: perr/ready got %b/%b want 0/1", proto_err, bus.req_ready);
      end
      for (int i = 0; i < 4; i++) begin
         bus.req_valid = 1'b1;
         step();
      end
      bus.req_valid = 1'b0;
      n_vec++;
      if ({bus.req_ready, bus.issue_sb_id} !== {1'b0, 5'd3}) begin
         n_err++; $display("FAIL proto_credits4: ready/last sb got %b/%0d want 0/3", bus.req_ready, bus.issue_sb_id);
      end
`else
      n_vec++;
      if (proto_err !== 1'b0) begin
         n_err++; $display("FAIL proto_tied: got %b want 0", proto_err);
      end
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_credits();
      test_dispatch();
      test_kill();
      test_wrap();
      test_reset_mid();
      test_proto();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
